// File: rtl/a2d_chnl_sched.sv
// a2d_chnl_sched: drives the shared A2D SPI monarch across the four analog inputs.
// Each conversion is two SPI transactions separated by a short idle gap.
// Battery requests are sticky and take priority over the round-robin slot.
// A per-transaction watchdog aborts a hung SPI.
module a2d_chnl_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6,
    parameter int         GAP_CYC  = 4,
    parameter int         TIMEOUT  = 2048
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        nxt_i,
    input  logic        batt_req_i,
    output logic        wrt_o,
    output logic [15:0] cmd_o,
    input  logic        done_i,
    input  logic [15:0] rd_data_i,
    output logic [11:0] lft_ld_o,
    output logic [11:0] rght_ld_o,
    output logic [11:0] steer_pot_o,
    output logic [11:0] batt_o,
    output logic [3:0]  upd_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  miss_cnt_o
);

    // One counter serves both the gap timer and the watchdog; size it for the larger.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Slot index: 0 lft, 1 rght, 2 steer, 3 batt (matches the upd bit order).
    localparam logic [1:0] SEL_BATT = 2'd3;

    typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               batt_pend_q, batt_pend_d;
    logic               wrt_q, wrt_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [3:0]         upd_q, upd_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [7:0]         miss_q, miss_d;
    logic [11:0]        lft_q, rght_q, steer_q, batt_q;
    logic               clr_batt;
    logic               batt_eff;
    logic               unused_rd_hi;

    // Only the 12-bit conversion result is meaningful.
    assign unused_rd_hi = ^rd_data_i[15:12];

    // A request arriving in the same clk as nxt still wins the slot.
    assign batt_eff = batt_pend_q | batt_req_i;

    function automatic logic [2:0] ch_of(input logic [1:0] sel);
        case (sel)
            2'd0:    ch_of = CH_LFT;
            2'd1:    ch_of = CH_RGHT;
            2'd2:    ch_of = CH_STEER;
            default: ch_of = CH_BATT;
        endcase
    endfunction

    // Next-state and registered-output logic for the conversion sequencer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q + 1'b1;
        cmd_d    = cmd_q;
        wrt_d    = 1'b0;
        upd_d    = 4'b0000;
        err_d    = 1'b0;
        clr_batt = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (nxt_i || batt_eff) begin
                    sel_d   = batt_eff ? SEL_BATT : rr_q;
                    cmd_d   = {2'b00, ch_of(sel_d), 11'h000};
                    wrt_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TX1;
                end
            end
            TX1: begin
                if (done_i) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    wrt_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TX2;
                end
            end
            TX2: begin
                if (done_i) begin
                    upd_d[sel_q] = 1'b1;
                    state_d      = IDLE;
                    if (sel_q == SEL_BATT) clr_batt = 1'b1;
                    else rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request in the completing clk must survive the clear.
        batt_pend_d = batt_req_i | (batt_pend_q & ~clr_batt);
        busy_d      = (state_d != IDLE);
        miss_d      = miss_q;
        if (nxt_i && (state_q != IDLE) && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
    end

    // Sequencer state and control outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            rr_q        <= 2'd0;
            cnt_q       <= '0;
            batt_pend_q <= 1'b0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            upd_q       <= 4'b0000;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            miss_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            batt_pend_q <= batt_pend_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            upd_q       <= upd_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            miss_q      <= miss_d;
        end
    end

    // Result registers load on the same condition that raises their upd strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
        end else begin
            if (upd_d[0]) lft_q   <= rd_data_i[11:0];
            if (upd_d[1]) rght_q  <= rd_data_i[11:0];
            if (upd_d[2]) steer_q <= rd_data_i[11:0];
            if (upd_d[3]) batt_q  <= rd_data_i[11:0];
        end
    end

    assign wrt_o       = wrt_q;
    assign cmd_o       = cmd_q;
    assign upd_o       = upd_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign miss_cnt_o  = miss_q;
    assign lft_ld_o    = lft_q;
    assign rght_ld_o   = rght_q;
    assign steer_pot_o = steer_q;
    assign batt_o      = batt_q;

endmodule

// File: tb/tb_a2d_chnl_sched.sv
// Directed bench for a2d_chnl_sched with a simple latency-based SPI monarch model.
module tb_a2d_chnl_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0, batt_req = 1'b0;
    logic        done_m = 1'b0, done_s = 1'b0;
    logic        done;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, busy, err;
    logic [15:0] cmd;
    logic [11:0] lft, rght, steer, batt;
    logic [3:0]  upd;
    logic [7:0]  miss;

    // second instance with a long watchdog for the overrun case; its SPI never answers
    logic        nxt2 = 1'b0;
    logic        wrt2, busy2, err2;
    logic [15:0] cmd2;
    logic [11:0] lft2, rght2, steer2, batt2;
    logic [3:0]  upd2;
    logic [7:0]  miss2;
    int          wrt2_n = 0;

    int n_tests = 0, n_fail = 0;

    // SPI model controls and observations
    int          spi_lat  = 5;
    bit          spi_hang = 1'b0;
    logic [11:0] spi_data = 12'h000;
    int          wrt_n = 0;
    bit          ph = 1'b0;
    logic [2:0]  ch_a = 3'd7, ch_b = 3'd7;
    time         t_wrt = 0, t_done = 0;
    int          gap_clks = -1;

    assign done = done_m | done_s;

    always #5 clk = ~clk;

    a2d_chnl_sched #(.GAP_CYC(4), .TIMEOUT(64)) u_dut (
        .clk_i(clk), .rst_i(rst), .nxt_i(nxt), .batt_req_i(batt_req),
        .wrt_o(wrt), .cmd_o(cmd), .done_i(done), .rd_data_i(rd_data),
        .lft_ld_o(lft), .rght_ld_o(rght), .steer_pot_o(steer), .batt_o(batt),
        .upd_o(upd), .busy_o(busy), .err_o(err), .miss_cnt_o(miss)
    );

    a2d_chnl_sched #(.GAP_CYC(4), .TIMEOUT(2048)) u_long (
        .clk_i(clk), .rst_i(rst), .nxt_i(nxt2), .batt_req_i(1'b0),
        .wrt_o(wrt2), .cmd_o(cmd2), .done_i(1'b0), .rd_data_i(16'h0000),
        .lft_ld_o(lft2), .rght_ld_o(rght2), .steer_pot_o(steer2), .batt_o(batt2),
        .upd_o(upd2), .busy_o(busy2), .err_o(err2), .miss_cnt_o(miss2)
    );

    always @(negedge clk) if (wrt2) wrt2_n++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // SPI monarch: answers each wrt after spi_lat clks with spi_data (upper nibble junk).
    initial begin
        forever begin
            @(negedge clk);
            if (rst || err) ph = 1'b0;
            else if (wrt) begin
                wrt_n++;
                t_wrt = $time;
                if (!ph) ch_a = cmd[13:11];
                else begin
                    ch_b     = cmd[13:11];
                    gap_clks = int'((t_wrt - t_done) / 10) - 1;
                end
                ph = ~ph;
                if (!spi_hang) begin
                    repeat (spi_lat - 1) @(negedge clk);
                    done_m  = 1'b1;
                    rd_data = {4'hA, spi_data};
                    t_done  = $time;
                    @(negedge clk);
                    done_m  = 1'b0;
                end
            end
        end
    end

    task automatic pulse_nxt(input bit with_batt);
        @(negedge clk);
        nxt = 1'b1;
        batt_req = with_batt;
        @(negedge clk);
        nxt = 1'b0;
        batt_req = 1'b0;
    endtask

    task automatic wait_upd(input string tag);
        int k = 0;
        while (k < 400 && upd == 4'b0000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_upd_seen"}, {31'd0, upd != 4'b0000}, 32'd1);
    endtask

    task automatic conv(input string tag, input logic [11:0] d, input logic [2:0] ch,
                        input logic [3:0] u);
        spi_data = d;
        pulse_nxt(1'b0);
        wait_upd(tag);
        chk({tag, "_upd"}, {28'd0, upd}, {28'd0, u});
        chk({tag, "_ch1"}, {29'd0, ch_a}, {29'd0, ch});
        chk({tag, "_ch2"}, {29'd0, ch_b}, {29'd0, ch});
        chk({tag, "_gap"}, gap_clks, 32'd4);
    endtask

    initial begin
        bit any;
        int k;
        // ---- reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wrt",  {31'd0, wrt},  32'd0);
        chk("rst_cmd",  {16'd0, cmd},  32'h0);
        chk("rst_upd",  {28'd0, upd},  32'h0);
        chk("rst_miss", {24'd0, miss}, 32'h0);
        chk("rst_err",  {31'd0, err},  32'd0);
        rst = 1'b0;

        // ---- one full conversion, then reset in the middle of the next one's TX2
        conv("pre", 12'h0AA, 3'd0, 4'b0001);
        chk("pre_lft", {20'd0, lft}, 32'h0AA);
        spi_data = 12'h0BB;
        pulse_nxt(1'b0);
        k = 0;
        while (k < 100 && wrt_n < 4) begin @(negedge clk); k++; end
        chk("rst_reach_tx2", wrt_n, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_wrt",  {31'd0, wrt},  32'd0);
        chk("mid_lft",  {20'd0, lft},  32'h0);
        chk("mid_rght", {20'd0, rght}, 32'h0);
        repeat (10) @(negedge clk);
        rst = 1'b0;

        // ---- round robin from LFT (also proves the pointer was reset)
        conv("rr0", 12'h123, 3'd0, 4'b0001);
        chk("rr0_lft", {20'd0, lft}, 32'h123);
        conv("rr1", 12'h456, 3'd4, 4'b0010);
        chk("rr1_rght", {20'd0, rght}, 32'h456);
        conv("rr2", 12'h789, 3'd5, 4'b0100);
        chk("rr2_steer", {20'd0, steer}, 32'h789);
        conv("rr3", 12'hABC, 3'd0, 4'b0001);
        chk("rr3_lft", {20'd0, lft}, 32'hABC);
        chk("rr3_rght", {20'd0, rght}, 32'h456);

        // ---- battery wins a coincident nxt; rr (now RGHT) is untouched
        spi_data = 12'hC00;
        pulse_nxt(1'b1);
        wait_upd("bat");
        chk("bat_upd", {28'd0, upd}, 32'b1000);
        chk("bat_ch",  {29'd0, ch_a}, 32'd6);
        chk("bat_val", {20'd0, batt}, 32'hC00);
        repeat (3) @(negedge clk);
        chk("bat_no_repeat", {31'd0, busy}, 32'd0);
        conv("bat_nx", 12'h5A5, 3'd4, 4'b0010);
        chk("bat_nx_rght", {20'd0, rght}, 32'h5A5);
        chk("miss_zero", {24'd0, miss}, 32'h0);

        // ---- timeout on STEER, then retry of the same channel
        spi_hang = 1'b1;
        pulse_nxt(1'b0);
        any = 1'b0;
        k = 0;
        while (k < 200 && !err) begin
            @(negedge clk);
            if (upd != 4'b0000) any = 1'b1;
            k++;
        end
        chk("to_err",  {31'd0, err}, 32'd1);
        chk("to_dly",  int'(($time - t_wrt) / 10), 32'd64);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_noupd", {31'd0, any}, 32'd0);
        chk("to_steer", {20'd0, steer}, 32'h789);
        @(negedge clk);
        chk("to_err_pulse", {31'd0, err}, 32'd0);
        spi_hang = 1'b0;
        conv("retry", 12'h321, 3'd5, 4'b0100);
        chk("retry_steer", {20'd0, steer}, 32'h321);

        // ---- stray done in IDLE
        repeat (3) @(negedge clk);
        k = wrt_n;
        done_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0;
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || wrt || upd != 4'b0000) any = 1'b1;
        end
        chk("stray_quiet", {31'd0, any}, 32'd0);
        chk("stray_wrt_n", wrt_n, k);

        // ---- overrun on the long-watchdog instance
        @(negedge clk);
        nxt2 = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("ovr_miss10", {24'd0, miss2}, 32'd10);
        repeat (290) @(negedge clk);
        nxt2 = 1'b0;
        @(negedge clk);
        chk("ovr_miss_sat", {24'd0, miss2}, 32'hFF);
        chk("ovr_wrt_n", wrt2_n, 32'd1);
        chk("ovr_busy", {31'd0, busy2}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
